// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
//   Converts a WIDTH-bit unsigned value to BCD with a sequential shift-add-3
//   converter (one bit per clock) and drives a time-multiplexed bank of DIGITS
//   7-segment displays. It supports optional leading-zero blanking and shows
//   dashes when the value does not fit in DIGITS decimal digits.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   load_i      request conversion of value_i (ignored while busy_o)
//   value_i     unsigned binary value, sampled on the accepting edge
//   busy_o      conversion in progress
//   done_o      one-cycle pulse: new result is on the display
//   overflow_o  latched with the result: value >= 10^DIGITS
//   seg_o       segments {g,f,e,d,c,b,a}, active-high
//   an_o        one-hot digit enable, an_o[0] = least significant digit
// -----------------------------------------------------------------------------
module bcd_scan_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  value_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [6:0]        seg_o,
    output logic [DIGITS-1:0] an_o
);

    // Number of decimal digits needed to hold 2^w - 1.
    function automatic int dec_digits(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    localparam int CONV = dec_digits(WIDTH);
    // The accumulator is at least DIGITS wide so the display copy never
    // reaches past it; the extra nibbles simply stay zero.
    localparam int NIB  = (CONV > DIGITS) ? CONV : DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    logic [1:0]          state_q,  state_d;
    logic [WIDTH-1:0]    shift_q,  shift_d;
    logic [NIB*4-1:0]    bcd_q,    bcd_d;
    logic [NIB*4-1:0]    bcd_adj;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic [DIGITS*4-1:0] disp_q,   disp_d;
    logic                ovf_q,    ovf_d;
    logic                done_q,   done_d;
    logic [PW-1:0]       pre_q,    pre_d;
    logic [IW-1:0]       idx_q,    idx_d;
    logic [6:0]          seg_q,    seg_d;
    logic [DIGITS-1:0]   an_q,     an_d;

    // Converter
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the case leaves it unassigned (which would infer a latch).
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        bcd_adj = bcd_q;
        for (int i = 0; i < NIB; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (load_i) begin
                    shift_d = value_i;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                disp_d = bcd_q[DIGITS*4-1:0];
                ovf_d  = 1'b0;
                for (int i = DIGITS; i < NIB; i++) begin
                    if (bcd_q[i*4 +: 4] != 4'd0) begin
                        ovf_d = 1'b1;
                    end
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scanner: seg and an are computed from next-state values so both
    // registers change on the same edge, including on a display update.
    always_comb begin
        logic       wrap;
        logic       zero_from;
        logic       blank_sel;
        logic [3:0] nib;

        wrap  = (pre_q == PW'(SCAN_DIV - 1));
        pre_d = wrap ? '0 : pre_q + PW'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        // Walk from the most significant digit down, tracking whether the
        // selected digit and all digits above it are zero.
        zero_from = 1'b1;
        blank_sel = 1'b0;
        nib       = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_from = zero_from & (disp_d[i*4 +: 4] == 4'd0);
            if (idx_d == IW'(i)) begin
                blank_sel = zero_from;
                nib       = disp_d[i*4 +: 4];
            end
        end

        if (ovf_d) begin
            seg_d = 7'h40;
        end else if ((BLANK_LZ != 0) && (idx_d != '0) && blank_sel) begin
            seg_d = 7'h00;
        end else begin
            seg_d = decode(nib);
        end
        an_d = DIGITS'(1) << idx_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h3F;
            an_q    <= DIGITS'(1);
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign overflow_o = ovf_q;
    assign seg_o      = seg_q;
    assign an_o       = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
//   Directed bench for bcd_scan_display. Four instances cover the parameter
//   sets of interest:
//     u0: WIDTH=8,  DIGITS=3, SCAN_DIV=4, BLANK_LZ=0
//     u1: WIDTH=8,  DIGITS=3, SCAN_DIV=4, BLANK_LZ=1
//     u2: WIDTH=8,  DIGITS=2, SCAN_DIV=4, BLANK_LZ=0
//     u3: WIDTH=16, DIGITS=5, SCAN_DIV=4, BLANK_LZ=0
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        load_a = 1'b0, load_b = 1'b0, load_c = 1'b0, load_d = 1'b0;
    logic [7:0]  val_a = '0, val_b = '0, val_c = '0;
    logic [15:0] val_d = '0;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;
    logic [6:0]  seg_a, seg_b, seg_c, seg_d;
    logic [2:0]  an_a, an_b;
    logic [1:0]  an_c;
    logic [4:0]  an_d;

    bcd_scan_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(SD), .BLANK_LZ(0)) u0 (
        .clk(clk), .rst(rst), .load_i(load_a), .value_i(val_a), .busy_o(busy_a),
        .done_o(done_a), .overflow_o(ovf_a), .seg_o(seg_a), .an_o(an_a));
    bcd_scan_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(SD), .BLANK_LZ(1)) u1 (
        .clk(clk), .rst(rst), .load_i(load_b), .value_i(val_b), .busy_o(busy_b),
        .done_o(done_b), .overflow_o(ovf_b), .seg_o(seg_b), .an_o(an_b));
    bcd_scan_display #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(SD), .BLANK_LZ(0)) u2 (
        .clk(clk), .rst(rst), .load_i(load_c), .value_i(val_c), .busy_o(busy_c),
        .done_o(done_c), .overflow_o(ovf_c), .seg_o(seg_c), .an_o(an_c));
    bcd_scan_display #(.WIDTH(16), .DIGITS(5), .SCAN_DIV(SD), .BLANK_LZ(0)) u3 (
        .clk(clk), .rst(rst), .load_i(load_d), .value_i(val_d), .busy_o(busy_d),
        .done_o(done_d), .overflow_o(ovf_d), .seg_o(seg_d), .an_o(an_d));

    // Uniform views of the four instances, indexed by unit number.
    logic       busy_w [4];
    logic       done_w [4];
    logic       ovf_w  [4];
    logic [6:0] seg_w  [4];
    logic [4:0] an_w   [4];

    assign busy_w[0] = busy_a;  assign busy_w[1] = busy_b;
    assign busy_w[2] = busy_c;  assign busy_w[3] = busy_d;
    assign done_w[0] = done_a;  assign done_w[1] = done_b;
    assign done_w[2] = done_c;  assign done_w[3] = done_d;
    assign ovf_w[0]  = ovf_a;   assign ovf_w[1]  = ovf_b;
    assign ovf_w[2]  = ovf_c;   assign ovf_w[3]  = ovf_d;
    assign seg_w[0]  = seg_a;   assign seg_w[1]  = seg_b;
    assign seg_w[2]  = seg_c;   assign seg_w[3]  = seg_d;
    assign an_w[0]   = {2'b00, an_a};
    assign an_w[1]   = {2'b00, an_b};
    assign an_w[2]   = {3'b000, an_c};
    assign an_w[3]   = an_d;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int u, input logic l, input logic [15:0] v);
        case (u)
            0: begin load_a = l; val_a = v[7:0]; end
            1: begin load_b = l; val_b = v[7:0]; end
            2: begin load_c = l; val_c = v[7:0]; end
            default: begin load_d = l; val_d = v; end
        endcase
    endtask

    // Waits (bounded) for done on unit u; returns negedges counted.
    task automatic wait_done(input int u, output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done_w[u]) begin
                n = i;
                break;
            end
        end
    endtask

    // Loads v into unit u, checks latency, busy and done pulse width.
    task automatic run_conv(input int u, input logic [15:0] v, input int exp_lat, input string tag);
        int n;
        drive(u, 1'b1, v);
        @(negedge clk);
        check({tag, " busy after accept"}, 32'(busy_w[u]), 32'd1);
        drive(u, 1'b0, 16'hFFFF);   // value changes after acceptance must not matter
        wait_done(u, n);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " busy at done"}, 32'(busy_w[u]), 32'd0);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done_w[u]), 32'd0);
    endtask

    // Aligns to the start of digit 0 and checks each digit for SD cycles.
    // exp packs the expected segment code of digit d at [d*7 +: 7].
    task automatic check_scan(input int u, input int nd, input logic [34:0] exp, input string tag);
        logic [4:0] prev;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            prev = an_w[u];
            @(negedge clk);
            if (an_w[u] == 5'd1 && prev != 5'd1) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, " scan align"}, 32'(found), 32'd1);
        for (int d = 0; d < nd; d++) begin
            for (int c = 0; c < SD; c++) begin
                check($sformatf("%s an d%0d c%0d", tag, d, c), 32'(an_w[u]), 32'(5'd1 << d));
                check($sformatf("%s seg d%0d c%0d", tag, d, c), 32'(seg_w[u]), 32'(exp[d*7 +: 7]));
                @(negedge clk);
            end
        end
        check({tag, " scan wrap"}, 32'(an_w[u]), 32'd1);
    endtask

    initial begin
        int  n;
        logic saw_done;

        // Reset state, both while held and after release
        repeat (2) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("rst u%0d busy", u), 32'(busy_w[u]), 32'd0);
            check($sformatf("rst u%0d done", u), 32'(done_w[u]), 32'd0);
            check($sformatf("rst u%0d ovf", u),  32'(ovf_w[u]),  32'd0);
            check($sformatf("rst u%0d an", u),   32'(an_w[u]),   32'd1);
            check($sformatf("rst u%0d seg", u),  32'(seg_w[u]),  32'h3F);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post-rst u0 seg", 32'(seg_w[0]), 32'h3F);

        // Reset in the middle of a 16-bit conversion aborts it silently
        drive(3, 1'b1, 16'd65535);
        @(negedge clk);
        drive(3, 1'b0, 16'd0);
        repeat (4) @(negedge clk);
        check("mid-shift busy", 32'(busy_d), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy_d), 32'd0);
        check("abort done", 32'(done_d), 32'd0);
        check("abort an",   32'(an_d),   32'd1);
        check("abort seg",  32'(seg_d),  32'h3F);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_d) saw_done = 1'b1;
        end
        check("abort no done", 32'(saw_done), 32'd0);

        // 255 on three digits: 2,5,5
        run_conv(0, 16'd255, 9, "u0 255");
        check("u0 255 ovf", 32'(ovf_a), 32'd0);
        check_scan(0, 3, {7'h00, 7'h00, 7'h5B, 7'h6D, 7'h6D}, "u0 255");

        // Leading-zero blanking
        run_conv(1, 16'd7, 9, "u1 7");
        check_scan(1, 3, {7'h00, 7'h00, 7'h00, 7'h00, 7'h07}, "u1 7");
        run_conv(1, 16'd100, 9, "u1 100");
        check_scan(1, 3, {7'h00, 7'h00, 7'h06, 7'h3F, 7'h3F}, "u1 100");

        // Overflow on two digits, then cleared by an in-range result
        run_conv(2, 16'd100, 9, "u2 100");
        check("u2 100 ovf", 32'(ovf_c), 32'd1);
        check_scan(2, 2, {7'h00, 7'h00, 7'h00, 7'h40, 7'h40}, "u2 100");
        run_conv(2, 16'd99, 9, "u2 99");
        check("u2 99 ovf", 32'(ovf_c), 32'd0);
        check_scan(2, 2, {7'h00, 7'h00, 7'h00, 7'h6F, 7'h6F}, "u2 99");

        // 16-bit full scale: 6,5,5,3,5
        run_conv(3, 16'd65535, 17, "u3 65535");
        check("u3 ovf", 32'(ovf_d), 32'd0);
        check_scan(3, 5, {7'h7D, 7'h6D, 7'h6D, 7'h4F, 7'h6D}, "u3 65535");

        // Load held high: 12 accepted, 34 dropped while busy, then 34
        // accepted on the edge after done
        drive(0, 1'b1, 16'd12);
        @(negedge clk);
        check("b2b busy 12", 32'(busy_a), 32'd1);
        drive(0, 1'b1, 16'd34);
        wait_done(0, n);
        check("b2b latency 12", 32'(n), 32'd9);
        check("b2b busy at done", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("b2b busy 34", 32'(busy_a), 32'd1);
        check("b2b done cleared", 32'(done_a), 32'd0);
        drive(0, 1'b0, 16'd0);
        wait_done(0, n);
        check("b2b latency 34", 32'(n), 32'd9);
        check_scan(0, 3, {7'h00, 7'h00, 7'h3F, 7'h4F, 7'h66}, "b2b 34");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Parametrised binary-to-decimal display driver: accepts a WIDTH-bit unsigned value on a load strobe and converts it to BCD sequentially (shift-add-3, one bit per clock). It drives a time-multiplexed bank of DIGITS common-segment 7-segment displays, with optional leading-zero blanking and overflow indication. It is the general successor to the fixed 4-bit, two-display decimal decoder, and sits between switch/datapath sources and the board display pins.

## Interface
- WIDTH, 8: input value width, 1..16.
- DIGITS, 3: number of physical digits driven, 1..5.
- SCAN_DIV, 1000: clock cycles each digit stays enabled, ≥1.
- BLANK_LZ, 0: 1 = blank leading zero digits (digit 0 never blanked).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  request conversion of `value`; honoured only when busy=0.
- value  in  WIDTH  unsigned binary input, sampled on the accepting edge.
- busy  out  1  conversion in progress; load ignored while high.
- done  out  1  one-cycle pulse: new result now on display.
- overflow  out  1  latched with result: value ≥ 10^DIGITS.
- seg  out  7  segments {g,f,e,d,c,b,a} (seg[0]=a), active-high.
- an  out  DIGITS  one-hot digit enable, active-high; an[0] = least significant digit.

## Operation
- Converter FSM states IDLE, SHIFT, LATCH.
- IDLE: load=1 → capture value into shift register, clear BCD accumulator (CONV = enough digits for 2^WIDTH−1), bit counter = WIDTH, busy=1, go SHIFT.
- SHIFT: each cycle, every BCD nibble ≥5 gets +3, then {bcd, shift} shifts left by 1; counter decrements; after the WIDTH-th shift go LATCH.
- LATCH: copy lowest DIGITS nibbles into display register; overflow = any nibble above DIGITS−1 nonzero; done=1 for one cycle; busy=0; go IDLE.
- load while busy (SHIFT or LATCH) is dropped, not queued. value changes after acceptance have no effect.
- Display register holds the last result until the next LATCH; scanning is independent of the converter.
- Scan: prescaler counts 0..SCAN_DIV−1; on wrap, digit index increments mod DIGITS. an = one-hot(index).
- Decode per digit: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, seg[6:0]).
- Blanking (BLANK_LZ=1): digit i>0 outputs seg=00 when it and every more significant displayed digit are zero.
- Overflow: every digit outputs dash seg=40 (g only), blanking suppressed, until the next result without overflow.

## Timing
- Load accepted on edge E0; busy high after E0; shifts on E1..E_WIDTH; LATCH cycle follows; done high after edge E_WIDTH+1 for exactly one cycle, with display and overflow updated on that same edge; busy low from that edge. Load-to-done latency: WIDTH+1 cycles.
- New load may be accepted on the edge after done goes high (back-to-back throughput WIDTH+2 cycles).
- Each digit enabled for exactly SCAN_DIV cycles; full refresh DIGITS×SCAN_DIV cycles. Display update does not reset the scan.
- seg and an are registered outputs of the same stage, so they change on the same edge — no cross-digit ghosting.
- Reset (any time, including mid-conversion): FSM IDLE, shift/BCD/counter cleared, display register = 0, prescaler = 0, index = 0, an = 1 (digit 0), seg = 3F, busy = 0, done = 0, overflow = 0. An aborted conversion produces no done.

## Test plan
- Reset: assert rst mid-SHIFT → immediately busy=0, done=0, an=001, seg=3F; no done after release.
- WIDTH=8, DIGITS=3, SCAN_DIV=4: load value=255 → done 9 cycles after accept; scan gives an=001/seg=6D, an=010/seg=6D, an=100/seg=5B, each for 4 cycles, then repeats.
- BLANK_LZ=1, value=7 → digit0 seg=07, digits 1,2 seg=00; value=100 → 3F,3F,06 (inner zeros shown).
- DIGITS=2, value=100 → overflow=1, all digits seg=40; then value=99 → overflow=0, 6F,6F.
- Load asserted every cycle with values 12 then 34 → only 12 accepted while busy; next accepted load is the one present on the edge after done.
- WIDTH=16, DIGITS=5, value=65535 → done after 17 cycles, digits 6,5,5,3,5 decode to 7D,6D,6D,4F,6D, overflow=0.
